// File: rtl/branch_comp_seq_if.sv
// Operand/result handshake bundle for the sliced branch comparator.
interface branch_comp_seq_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   funct3;
    logic         out_valid;
    logic         out_ready;
    logic         eq;
    logic         lt;
    logic         taken;
    logic         err;

    modport master (
        output in_valid, a, b, funct3, out_ready,
        input  in_ready, out_valid, eq, lt, taken, err
    );

    modport slave (
        input  in_valid, a, b, funct3, out_ready,
        output in_ready, out_valid, eq, lt, taken, err
    );
endinterface

// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: walks CHUNK-bit slices MSB-first, stops at the
// first differing slice, and resolves the RISC-V branch funct3 into taken/err.
module branch_comp_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst,
    branch_comp_seq_if.slave    bus
);
    localparam int unsigned K     = N / CHUNK;
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(K - 1);
    localparam logic [N-1:0]     MSB     = {1'b1, {(N-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             taken_q, taken_d;
    logic             err_q, err_d;

    logic [CHUNK-1:0] slice_a_c;
    logic [CHUNK-1:0] slice_b_c;

    // Operands are shifted left as slices match, so the live slice is always on top.
    assign slice_a_c = a_q[N-1 -: CHUNK];
    assign slice_b_c = b_q[N-1 -: CHUNK];

    // Returns {err, taken} for a resolved compare.
    function automatic logic [1:0] decode(input logic e, input logic l, input logic [2:0] f3);
        logic [1:0] r;
        case (f3)
            3'b000:         r = {1'b0, e};
            3'b001:         r = {1'b0, ~e};
            3'b100, 3'b110: r = {1'b0, l};
            3'b101, 3'b111: r = {1'b0, ~l};
            default:        r = 2'b10;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        f3_d        = f3_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        taken_d     = taken_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Flipping the sign bit makes a signed compare an unsigned one.
                    a_d     = bus.funct3[1] ? bus.a : (bus.a ^ MSB);
                    b_d     = bus.funct3[1] ? bus.b : (bus.b ^ MSB);
                    f3_d    = bus.funct3;
                    idx_d   = IDX_TOP;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (slice_a_c != slice_b_c) begin
                    eq_d        = 1'b0;
                    lt_d        = (slice_a_c < slice_b_c);
                    {err_d, taken_d} = decode(1'b0, slice_a_c < slice_b_c, f3_q);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d        = 1'b1;
                    lt_d        = 1'b0;
                    {err_d, taken_d} = decode(1'b1, 1'b0, f3_q);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f3_q        <= '0;
            idx_q       <= IDX_TOP;
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            taken_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f3_q        <= f3_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            taken_q     <= taken_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;
    assign bus.taken     = taken_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_branch_comp_seq.sv
// Runs a CHUNK=8 and a CHUNK=32 comparator side by side on shared stimulus
// and checks both against a behavioural branch-resolution model.
module tb_branch_comp_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_comp_seq_if #(.N(32)) bus8 ();
    branch_comp_seq_if #(.N(32)) bus32 ();

    assign bus8.in_valid   = in_valid;
    assign bus8.a          = a;
    assign bus8.b          = b;
    assign bus8.funct3     = funct3;
    assign bus8.out_ready  = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.a         = a;
    assign bus32.b         = b;
    assign bus32.funct3    = funct3;
    assign bus32.out_ready = out_ready;

    branch_comp_seq #(.N(32), .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    branch_comp_seq #(.N(32), .CHUNK(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: branch semantics from plain arithmetic; latency from the top differing bit.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] f3,
                                  output logic e, output logic l, output logic t, output logic er,
                                  output int m8);
        logic [31:0] diff;
        int hb;
        e  = (ma == mb);
        l  = f3[1] ? (ma < mb) : ($signed(ma) < $signed(mb));
        er = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:         t = e;
            3'b001:         t = !e;
            3'b100, 3'b110: t = l;
            3'b101, 3'b111: t = !l;
            default:        t = 1'b0;
        endcase
        diff = ma ^ mb;
        hb = -1;
        for (int i = 0; i < 32; i++) if (diff[i]) hb = i;
        m8 = (hb < 0) ? 4 : 4 - hb / 8;
    endfunction

    task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf, input int hold);
        logic e, l, t, er;
        int m8, lat8, lat32;
        model(ta, tb, tf, e, l, t, er, m8);
        a = ta; b = tb; funct3 = tf; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat8 = 99; lat32 = 99;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lat8 == 99 && bus8.out_valid) lat8 = c;
            if (lat32 == 99 && bus32.out_valid) lat32 = c;
            if (lat8 != 99 && lat32 != 99) break;
        end
        check("lat8", lat8, m8);
        check("lat32", lat32, 1);
        for (int h = 0; h <= hold; h++) begin
            check("eq8", bus8.eq, e);      check("eq32", bus32.eq, e);
            check("lt8", bus8.lt, l);      check("lt32", bus32.lt, l);
            check("taken8", bus8.taken, t); check("taken32", bus32.taken, t);
            check("err8", bus8.err, er);   check("err32", bus32.err, er);
            check("ovalid8", bus8.out_valid, 1); check("ovalid32", bus32.out_valid, 1);
            check("irdy_busy8", bus8.in_ready, 0); check("irdy_busy32", bus32.in_ready, 0);
            if (h == hold) break;
            in_valid = (h == 1);
            a = $urandom; b = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ovalid_drop8", bus8.out_valid, 0); check("ovalid_drop32", bus32.out_valid, 0);
        check("irdy_back8", bus8.in_ready, 1);    check("irdy_back32", bus32.in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; funct3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", bus8.out_valid, 0);
        check("rst_eq", bus8.eq, 0);
        check("rst_lt", bus8.lt, 0);
        check("rst_taken", bus8.taken, 0);
        check("rst_err", bus8.err, 0);
        check("rst_irdy", bus8.in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_irdy_rel", bus8.in_ready, 1);
        @(negedge clk);

        run_txn(32'h0000_0005, 32'h0000_0005, 3'b000, 0);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0);
        run_txn(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0);
        run_txn(32'h1234_5600, 32'h1234_5601, 3'b111, 0);
        run_txn(32'hA5A5_0000, 32'hA5A4_FFFF, 3'b001, 5);
        run_txn(32'h0BAD_F00D, 32'h0BAD_F00D, 3'b010, 0);
        run_txn(32'h0000_0000, 32'h0000_0000, 3'b011, 1);

        // Reset mid-compare discards the in-flight result.
        a = '0; b = '0; funct3 = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ovalid8", bus8.out_valid, 0);
        check("midrst_ovalid32", bus32.out_valid, 0);
        check("midrst_irdy", bus8.in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_irdy_rel8", bus8.in_ready, 1);
        check("midrst_irdy_rel32", bus32.in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_quiet8", bus8.out_valid, 0);
        end

        // Reset wins over a simultaneous in_valid.
        rst = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h2; funct3 = 3'b100;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstwin_ovalid8", bus8.out_valid, 0);
            check("rstwin_ovalid32", bus32.out_valid, 0);
        end
        check("rstwin_irdy", bus8.in_ready, 1);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2:       rb = {ra[31:16], 16'($urandom)};
                default: rb = $urandom;
            endcase
            rf = 3'($urandom_range(0, 7));
            run_txn(ra, rb, rf, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_comp_seq.md
# branch_comp_seq

Multi-cycle, parametrised branch comparator and resolver for the RISC-V core. It compares two N-bit operands one CHUNK-bit slice per cycle, starting at the most-significant slice and stopping at the first slice that differs. It decodes the RISC-V branch funct3 into a taken/not-taken decision. Valid/ready handshakes on both sides let it sit between operand read and branch redirect in deeper or wider datapaths where a single-cycle N-bit compare does not meet timing.

## Interface
- N, 32: operand width; N must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle, 1..N. K = N/CHUNK slices. CHUNK = N gives a single-cycle compare.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and funct3 are valid.
- in_ready  out  1  block can accept; high only in IDLE and only while rst is low.
- a  in  N  operand rs1.
- b  in  N  operand rs2.
- funct3  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- eq  out  1  a == b.
- lt  out  1  a < b; signed when funct3[1]=0, unsigned when funct3[1]=1.
- taken  out  1  branch decision.
- err  out  1  funct3 was 010 or 011 (illegal); taken forced to 0.

## Operation
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch a, b and funct3, set slice index idx=K-1, and go to CMP.
- CMP: each cycle compare slice idx of the latched operands.
  - Signed mode: the top slice is compared with bit N-1 of both operands inverted. Lower slices are always compared unsigned.
  - Slices differ: register eq=0 and lt=(a_slice<b_slice), then go to DONE.
  - Slices equal and idx==0: register eq=1 and lt=0, then go to DONE.
  - Slices equal and idx>0: decrement idx and stay in CMP.
- DONE:
  - out_valid=1.
  - taken is decoded from the registered eq/lt and funct3:
    - BEQ: eq
    - BNE: !eq
    - BLT, BLTU: lt
    - BGE, BGEU: !lt
    - 010 or 011: err=1, taken=0.
  - On out_ready, go to IDLE.
- All outputs are stable while out_valid=1 and out_ready=0.
- in_valid is ignored outside IDLE; there is no overlap of operations.
- eq does not depend on mode. err does not affect eq or lt.
- Reset values: state IDLE, out_valid=0, eq=0, lt=0, taken=0, err=0, idx=K-1. in_ready=0 while rst is high.

## Timing
- Acceptance edge is E0. With m = number of slices examined (1..K), out_valid rises m cycles after E0.
- Best-case latency is 1 cycle (top slice differs). Worst-case is K cycles (operands equal or differ only in slice 0).
- Handshake on the result side completes on the edge where out_valid & out_ready. in_ready rises the following cycle.
- Minimum issue interval is m+2 cycles, with out_ready held high.
- rst high in any state: at the next edge the block is in IDLE, out_valid=0, and the in-flight result is discarded (never presented). in_ready returns to 1 in the first cycle that rst is low.
- Simultaneous rst and in_valid: reset wins; nothing is accepted.

## Test plan
- N=32, CHUNK=8, a=b=0x00000005, BEQ -> out_valid 4 cycles after acceptance; eq=1, lt=0, taken=1, err=0.
- a=0xFFFFFFFF, b=0x00000001:
  - BLT -> latency 1; lt=1, taken=1.
  - Same operands, BLTU -> latency 1; lt=0, taken=0.
- a=0x80000000, b=0x7FFFFFFF, BGE -> lt=1, taken=0.
- a=0x12345600, b=0x12345601, BGEU -> latency 4; lt=1, taken=0.
- out_ready held low 5 cycles after out_valid, with in_valid pulsed meanwhile -> eq/lt/taken/out_valid constant, in_ready=0, the pulse is not accepted. in_ready rises 1 cycle after the out_ready handshake.
- rst asserted 2 cycles after accepting a=b=0 -> out_valid never rises, state returns to IDLE, in_ready=1 the cycle after rst drops.
- funct3=010 with a=b -> eq=1, err=1, taken=0.
- Repeat the first three scenarios with CHUNK=32 -> latency 1 and identical results.
